// File: rtl/store_drain_unit_pkg.sv
// Shared types for the store drain unit: FSM state, held write request and the
// optional statistics bundle (only present when STORE_DRAIN_STATS_EN is defined).
package store_drain_unit_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } store_drain_state_t;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } store_drain_req_t;

`ifdef STORE_DRAIN_STATS_EN
    typedef struct packed {
        logic [31:0] writes;
        logic [31:0] credit_stalls;
        logic [31:0] bus_stalls;
    } store_drain_stats_t;
`endif

    // Byte address to word address: the bus only ever sees word-aligned writes.
    function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/store_drain_unit_stats.sv
// Event counters for the store drain unit: accepted writes, credit stalls and
// bus stalls. All counters reset to zero and wrap on overflow.
// Only instantiated when STORE_DRAIN_STATS_EN is defined.
module store_drain_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        accept_i,
    input  logic        credit_stall_i,
    input  logic        bus_stall_i,
    output logic [31:0] stat_writes_o,
    output logic [31:0] stat_credit_stalls_o,
    output logic [31:0] stat_bus_stalls_o
);
    logic [2:0]  inc;
    logic [31:0] cnt_q [3];

    assign inc = {bus_stall_i, credit_stall_i, accept_i};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            // One free-running wrap-around counter per event.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q[gi] <= '0;
                end else if (inc[gi]) begin
                    cnt_q[gi] <= cnt_q[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign stat_writes_o        = cnt_q[0];
    assign stat_credit_stalls_o = cnt_q[1];
    assign stat_bus_stalls_o    = cnt_q[2];

endmodule

// File: rtl/store_drain_unit.sv
// Store drain unit: pops released stores from the store queue, issues them as
// word-aligned writes, limits writes awaiting ack, and completes fences.
// Optional statistics outputs are enabled by defining STORE_DRAIN_STATS_EN.
module store_drain_unit
    import store_drain_unit_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sq_valid,
    input  logic [31:0] sq_addr,
    input  logic [3:0]  sq_be,
    input  logic [31:0] sq_data,
    output logic        sq_pop,
    input  logic        sq_no_released_pending,
    input  logic        fence_req,
    output logic        fence_done,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_ack,
    output logic        idle
`ifdef STORE_DRAIN_STATS_EN
    ,
    output logic [31:0] stat_writes,
    output logic [31:0] stat_credit_stalls,
    output logic [31:0] stat_bus_stalls
`endif
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W:0] MAX_C = (CNT_W + 1)'(MAX_OUTSTANDING);

    store_drain_req_t   req_q;
    logic               mem_req_q, mem_req_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    store_drain_state_t state_q;
    logic               fence_done_q;

    logic [CNT_W:0]     inflight;
    logic               credit_ok;
    logic               accept;
    logic               drain_ok;
    logic               unused_addr_lsb;

    // The low address bits are implied by the lane-aligned byte enables.
    assign unused_addr_lsb = &{1'b0, sq_addr[1:0]};

    // Conservative credit: a held but not yet accepted request already uses a slot.
    assign inflight  = {1'b0, outstanding_q} + {{CNT_W{1'b0}}, mem_req_q};
    assign credit_ok = inflight < MAX_C;
    assign sq_pop    = sq_valid & credit_ok & (~mem_req_q | mem_ready) & ~rst;
    assign accept    = mem_req_q & mem_ready;
    assign mem_req_d = sq_pop | (mem_req_q & ~mem_ready);

    // Outstanding count: +1 on accept, -1 on ack, saturating at zero on a stray ack.
    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !mem_ack) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (mem_ack && !accept && outstanding_q != '0) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    assign drain_ok = sq_no_released_pending & ~mem_req_q & ~sq_pop & (outstanding_d == '0);

    // Request valid and credit counter; both are dropped by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_q     <= 1'b0;
            outstanding_q <= '0;
        end else begin
            mem_req_q     <= mem_req_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Request payload: loads only on a pop, so it is stable while the bus stalls.
    always_ff @(posedge clk) begin
        if (sq_pop) begin
            req_q <= '{addr: word_addr(sq_addr), be: sq_be, data: sq_data};
        end
    end

    // Fence FSM: waits for every prior store to be acked, then pulses fence_done once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fence_done_q <= 1'b0;
        end else begin
            fence_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fence_req) begin
                        if (drain_ok) begin
                            fence_done_q <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_ok) begin
                        state_q      <= IDLE;
                        fence_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = req_q.addr;
    assign mem_be     = req_q.be;
    assign mem_wdata  = req_q.data;
    assign fence_done = fence_done_q;
    assign idle       = ~mem_req_q & (outstanding_q == '0);

    // An ack with nothing outstanding is a bus protocol error.
    a_no_stray_ack: assert property (@(posedge clk) disable iff (rst)
        !(mem_ack && outstanding_q == '0));

    // The credit rule must make an accept at full occupancy impossible.
    a_no_overcredit: assert property (@(posedge clk) disable iff (rst)
        !(accept && {1'b0, outstanding_q} == MAX_C));

`ifdef STORE_DRAIN_STATS_EN
    store_drain_stats u_stats (
        .clk                  (clk),
        .rst                  (rst),
        .accept_i             (accept),
        .credit_stall_i       (sq_valid & ~credit_ok),
        .bus_stall_i          (mem_req_q & ~mem_ready),
        .stat_writes_o        (stat_writes),
        .stat_credit_stalls_o (stat_credit_stalls),
        .stat_bus_stalls_o    (stat_bus_stalls)
    );
`endif

endmodule
